id_ex_register: RTL and testbench

- Pipeline register between the decode stage (register file read, control decode, immediate extension) and the execute stage of the 5-stage MIPS pipeline.
- Captures decoded operands, the 32-bit extended immediate, register indices and control bits.
- Supports stall (hold) and flush (bubble insertion).
- Also provides the load-use hazard detect signal and a saturating bubble counter for performance debug.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_register.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_register.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU op encodings and
// the decoded control bundle used by decode, id_ex_register and ex_mem_register.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;
  localparam int SHAMT_W    = 5;

  // ALU operation encodings produced by the control decoder.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_e;

  // Single-bit decoded control fields.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_bits_t;

  // Full control bundle as it travels down the pipe.
  typedef struct packed {
    ctrl_bits_t bits;
    alu_op_e    alu_op;
  } ctrl_t;

  localparam ctrl_bits_t CTRL_NOP = '0;

  // Strip every control bit that changes architectural state (register file
  // or memory), leaving the pure datapath-steering bits intact.
  function automatic ctrl_bits_t squash_side_effects(input ctrl_bits_t c);
    ctrl_bits_t r;
    r           = c;
    r.reg_write = 1'b0;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare: an in-flight load whose destination matches
// either source of the instruction behind it. Also reused for branch-in-ID.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              valid,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] load_rt,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              hazard
);

  logic dst_live;
  logic src_match;

  // $zero never carries a dependency, so a load targeting it is ignored.
  always_comb begin
    dst_live  = valid && mem_read && (load_rt != '0);
    src_match = (load_rt == src_a) || (load_rt == src_b);
    hazard    = dst_live && src_match;
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall/flush, load-use hazard detect and a
// saturating bubble counter for performance debug.
module id_ex_register
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int ALU_OP_WIDTH   = ALU_OP_W,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_ext_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [4:0]                id_shamt,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      id_mem_to_reg,
  input  logic                      id_alu_src,
  input  logic                      id_reg_dst,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
  output logic [DATA_WIDTH-1:0]     ex_rs_data,
  output logic [DATA_WIDTH-1:0]     ex_rt_data,
  output logic [DATA_WIDTH-1:0]     ex_ext_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [4:0]                ex_shamt,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_mem_to_reg,
  output logic                      ex_alu_src,
  output logic                      ex_reg_dst,
  output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
  output logic                      load_use_hazard,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  logic                      valid_d,  valid_q;
  logic [DATA_WIDTH-1:0]     pc_d,     pc_q;
  logic [DATA_WIDTH-1:0]     rs_data_d, rs_data_q;
  logic [DATA_WIDTH-1:0]     rt_data_d, rt_data_q;
  logic [DATA_WIDTH-1:0]     imm_d,    imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs_d,     rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_d,     rt_q;
  logic [REG_ADDR_WIDTH-1:0] rd_d,     rd_q;
  logic [4:0]                shamt_d,  shamt_q;
  ctrl_bits_t                ctrl_d,   ctrl_q;
  logic [ALU_OP_WIDTH-1:0]   alu_op_d, alu_op_q;
  logic [CNT_WIDTH-1:0]      cnt_d,    cnt_q;

  ctrl_bits_t id_ctrl;

  // Gather the decoded control bits; an invalid slot must not write anything.
  always_comb begin
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.reg_dst    = id_reg_dst;
    if (!id_valid) id_ctrl = squash_side_effects(id_ctrl);
  end

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    shamt_d   = shamt_q;
    ctrl_d    = ctrl_q;
    alu_op_d  = alu_op_q;
    cnt_d     = cnt_q;
    if (flush) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      shamt_d   = '0;
      ctrl_d    = CTRL_NOP;
      alu_op_d  = '0;
      // Saturate rather than wrap so a long run never reads as "few bubbles".
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!stall) begin
      valid_d   = id_valid;
      pc_d      = id_pc_plus4;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_ext_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      shamt_d   = id_shamt;
      ctrl_d    = id_ctrl;
      alu_op_d  = id_alu_op;
    end
  end

  // Pipeline state; reset presents a bubble and clears the debug counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      ctrl_q    <= CTRL_NOP;
      alu_op_q  <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      shamt_q   <= shamt_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs come straight from flops; no id_* input reaches ex_* in the same cycle.
  always_comb begin
    ex_valid      = valid_q;
    ex_pc_plus4   = pc_q;
    ex_rs_data    = rs_data_q;
    ex_rt_data    = rt_data_q;
    ex_ext_imm    = imm_q;
    ex_rs         = rs_q;
    ex_rt         = rt_q;
    ex_rd         = rd_q;
    ex_shamt      = shamt_q;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_to_reg = ctrl_q.mem_to_reg;
    ex_alu_src    = ctrl_q.alu_src;
    ex_reg_dst    = ctrl_q.reg_dst;
    ex_alu_op     = alu_op_q;
    bubble_count  = cnt_q;
  end

  hazard_detect #(
    .ADDR_W (REG_ADDR_WIDTH)
  ) u_hazard (
    .valid    (valid_q),
    .mem_read (ctrl_q.mem_read),
    .load_rt  (rt_q),
    .src_a    (id_rs),
    .src_b    (id_rt),
    .hazard   (load_use_hazard)
  );

endmodule

// File: tb/tb_id_ex_register.sv
// Directed + randomized bench for id_ex_register against a transaction-level model.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_ext_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_op;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_ext_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu_op;
  logic        load_use_hazard;
  logic [3:0]  bubble_count;

  always #5 clk = ~clk;

  id_ex_register #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_ext_imm(id_ext_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_ext_imm(ex_ext_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
    .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
  );

  // One pipeline slot as seen at the EX side.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic        rw, mr, mw, m2r, asrc, rdst;
    logic [3:0]  aluop;
  } slot_t;

  slot_t exp_slot, nxt_slot, saved;
  int    exp_cnt, nxt_cnt;
  int    total = 0;
  int    bad   = 0;

  function automatic slot_t observed();
    slot_t s;
    s = '{ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_ext_imm, ex_rs, ex_rt, ex_rd,
          ex_shamt, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
          ex_reg_dst, ex_alu_op};
    return s;
  endfunction

  // What a loaded slot should look like: a copy, minus side effects if not valid.
  function automatic slot_t from_id();
    slot_t s;
    s = '{id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_ext_imm, id_rs, id_rt, id_rd,
          id_shamt, id_reg_write && id_valid, id_mem_read && id_valid,
          id_mem_write && id_valid, id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op};
    return s;
  endfunction

  function automatic logic exp_hazard();
    return exp_slot.valid && exp_slot.mr && (exp_slot.rt != 0) &&
           (exp_slot.rt == id_rs || exp_slot.rt == id_rt);
  endfunction

  task automatic check_regs(input string tag);
    total++;
    assert (observed() === exp_slot) else begin
      bad++;
      $error("FAIL %s regs got=%h exp=%h", tag, observed(), exp_slot);
    end
    total++;
    assert (bubble_count === 4'(exp_cnt)) else begin
      bad++;
      $error("FAIL %s bubble_count got=%0d exp=%0d", tag, bubble_count, exp_cnt);
    end
  endtask

  task automatic check_haz(input string tag);
    logic e;
    e = exp_hazard();
    total++;
    assert (load_use_hazard === e) else begin
      bad++;
      $error("FAIL %s load_use_hazard got=%b exp=%b", tag, load_use_hazard, e);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, want);
    end
  endtask

  task automatic zero_inputs();
    id_valid = 0; id_pc_plus4 = 0; id_rs_data = 0; id_rt_data = 0; id_ext_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0; id_alu_src = 0; id_reg_dst = 0; id_alu_op = 0;
  endtask

  task automatic rand_inputs();
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
    id_ext_imm = $urandom;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom); id_shamt = 5'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
    id_alu_op = 4'($urandom);
  endtask

  // Present inputs, check the hazard, clock once, then check the new slot.
  task automatic cycle(input logic st, input logic fl, input string tag);
    stall = st; flush = fl;
    #1 check_haz(tag);
    if (fl) begin
      nxt_slot = '0;
      nxt_cnt  = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    end else if (!st) begin
      nxt_slot = from_id();
      nxt_cnt  = exp_cnt;
    end else begin
      nxt_slot = exp_slot;
      nxt_cnt  = exp_cnt;
    end
    @(posedge clk); #1;
    exp_slot = nxt_slot;
    exp_cnt  = nxt_cnt;
    check_regs(tag);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    zero_inputs();
    exp_slot = '0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 check_regs("reset");
    check_haz("reset_haz");
    rst = 0;

    // Normal load with a sign-extended immediate.
    id_valid = 1; id_ext_imm = 32'hFFFF8000; id_rt = 9; id_alu_op = 4'h2; id_reg_write = 1;
    cycle(0, 0, "load");
    check_bit("load_imm", ex_ext_imm === 32'hFFFF8000, 1'b1);
    check_bit("load_rt", ex_rt === 5'd9, 1'b1);

    // Load A, then hold it for three stalled cycles while inputs churn.
    rand_inputs(); id_valid = 1;
    cycle(0, 0, "load_a");
    saved = exp_slot;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle(1, 0, "stall");
      check_bit("stall_hold", observed() === saved, 1'b1);
    end

    // Flush wins over a simultaneous stall.
    rand_inputs(); id_valid = 1;
    cycle(1, 1, "flush_prio");
    check_bit("flush_valid", ex_valid, 1'b0);
    check_bit("flush_cnt1", bubble_count === 4'd1, 1'b1);

    // Load-use hazard scenarios.
    zero_inputs(); id_valid = 1; id_mem_read = 1; id_rt = 8;
    cycle(0, 0, "haz_load");
    id_rs = 8; id_rt = 3;
    #1 check_haz("haz_rs_match");
    check_bit("haz_on", load_use_hazard, 1'b1);
    id_rs = 7; id_rt = 3;
    #1 check_haz("haz_no_match");
    check_bit("haz_off", load_use_hazard, 1'b0);
    zero_inputs(); id_valid = 1; id_mem_read = 1; id_rt = 0;
    cycle(0, 0, "haz_zero_load");
    id_rs = 0; id_rt = 0;
    #1 check_haz("haz_zero");
    check_bit("haz_zero_off", load_use_hazard, 1'b0);

    // Invalid slot must not carry a memory write.
    rand_inputs(); id_valid = 0; id_mem_write = 1;
    cycle(0, 0, "invalid");
    check_bit("invalid_mw", ex_mem_write, 1'b0);

    // Asynchronous reset mid-operation, between clock edges.
    rand_inputs(); id_valid = 1; id_rs_data = 32'h12345678;
    cycle(0, 0, "pre_reset");
    #2 rst = 1;
    #1 exp_slot = '0; exp_cnt = 0;
    check_regs("async_reset");
    check_haz("async_reset_haz");
    #1 rst = 0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "random");
    end

    // Saturation: 20 flushes pin the 4-bit counter at 15.
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      cycle(1'($urandom), 1'b1, "sat_flush");
    end
    check_bit("sat_15", bubble_count === 4'd15, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      cycle(1'($urandom), 1'($urandom), "sat_hold");
    end
    check_bit("sat_stays", bubble_count === 4'd15, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
